// File: rtl/shft_sched.sv
// Round-robin scheduler for the load/shift register: grants one of two requesters,
// loads its word into the shifter, frames the serial-out cycles and inserts an idle gap.
module shft_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             dir0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             dir1,
    input  logic [WIDTH-1:0] data1,
    input  logic             flush,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sh_load,
    output logic             sh_dir,
    output logic [WIDTH-1:0] sh_ld,
    output logic             bit_vld,
    output logic             busy,
    output logic             owner,
    output logic [7:0]       frame_cnt
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    localparam int unsigned CntW = 5;
    localparam logic [CntW-1:0] LastShift = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] LastGap   = (GAP == 0) ? '0 : CntW'(GAP - 1);

    logic [1:0]       r_state, w_state;
    logic [CntW-1:0]  r_cnt, w_cnt;
    logic             r_last, w_last;
    logic             r_owner, w_owner;
    logic             r_sh_dir, w_sh_dir;
    logic [WIDTH-1:0] r_sh_ld, w_sh_ld;
    logic [7:0]       r_frame_cnt, w_frame_cnt;
    logic             w_pick1;

    // On a tie the requester that did not win last time takes the slot.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last      = r_last;
        w_owner     = r_owner;
        w_sh_dir    = r_sh_dir;
        w_sh_ld     = r_sh_ld;
        w_frame_cnt = r_frame_cnt;
        case (r_state)
            StIdle: begin
                w_cnt = '0;
                if (req0 | req1) begin
                    w_state  = StLoad;
                    w_owner  = w_pick1;
                    w_last   = w_pick1;
                    w_sh_ld  = w_pick1 ? data1 : data0;
                    w_sh_dir = w_pick1 ? dir1 : dir0;
                end
            end
            StLoad: begin
                w_cnt   = '0;
                w_state = flush ? StIdle : StShift;
            end
            StShift: begin
                if (flush) begin
                    w_state = StIdle;
                    w_cnt   = '0;
                end else if (r_cnt == LastShift) begin
                    w_frame_cnt = r_frame_cnt + 8'd1;
                    w_cnt       = '0;
                    w_state     = (GAP == 0) ? StIdle : StGap;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StGap: begin
                if (flush || (r_cnt == LastGap)) begin
                    w_state = StIdle;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = StIdle;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_sh_dir    <= 1'b0;
            r_sh_ld     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_last      <= w_last;
            r_owner     <= w_owner;
            r_sh_dir    <= w_sh_dir;
            r_sh_ld     <= w_sh_ld;
            r_frame_cnt <= w_frame_cnt;
        end
    end

    assign sh_load   = (r_state == StLoad);
    assign gnt0      = sh_load & ~r_owner;
    assign gnt1      = sh_load & r_owner;
    assign bit_vld   = (r_state == StShift);
    assign busy      = (r_state != StIdle);
    assign sh_dir    = r_sh_dir;
    assign sh_ld     = r_sh_ld;
    assign owner     = r_owner;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_shft_sched.sv
// Bench for shft_sched: grant scoreboard, table-driven arbitration frames and
// hand-written flush / reset sequences.
module tb_shft_sched;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic         req0, dir0, req1, dir1, flush;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, sh_load, sh_dir, bit_vld, busy, owner;
    logic [W-1:0] sh_ld;
    logic [7:0]   frame_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_grant = 0;

    typedef struct {
        logic         own;
        logic [W-1:0] word;
        logic         dir;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic         r0;
        logic         r1;
        logic         d0;
        logic         d1;
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic         own;
        int           gap;
    } vec_t;
    vec_t tbl[5];

    shft_sched #(.WIDTH(W), .GAP(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req0      (req0),
        .dir0      (dir0),
        .data0     (data0),
        .req1      (req1),
        .dir1      (dir1),
        .data1     (data1),
        .flush     (flush),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sh_load   (sh_load),
        .sh_dir    (sh_dir),
        .sh_ld     (sh_ld),
        .bit_vld   (bit_vld),
        .busy      (busy),
        .owner     (owner),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic own, input logic [W-1:0] word, input logic dir);
        exp_t e;
        e.own  = own;
        e.word = word;
        e.dir  = dir;
        sb.push_back(e);
    endfunction

    // Advance one cycle; any load cycle is checked against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sh_load === 1'b1) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt0", 32'(gnt0), 32'(!e.own));
                check("gnt1", 32'(gnt1), 32'(e.own));
                check("owner", 32'(owner), 32'(e.own));
                check("sh_ld", 32'(sh_ld), 32'(e.word));
                check("sh_dir", 32'(sh_dir), 32'(e.dir));
            end
            last_grant = cyc;
        end
    endtask

    task automatic wait_grant(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (sh_load === 1'b1) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        int nbusy;
        int hold_err;
        int g0;

        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA9, 8'h56, 1'b1, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h56, 1'b0, 12};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h56, 1'b1, 12};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 8'h56, 1'b0, 12};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h42, 8'h56, 1'b1, 12};

        rstn  = 1'b0;
        req0  = 1'b1;
        dir0  = 1'b1;
        data0 = 8'hA9;
        req1  = 1'b0;
        dir1  = 1'b0;
        data1 = 8'h56;
        flush = 1'b0;

        // Reset held with a pending request
        repeat (3) step();
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_sh_load", 32'(sh_load), 32'd0);
        check("rst_bit_vld", 32'(bit_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_sh_ld", 32'(sh_ld), 32'd0);

        // Single frame
        rstn = 1'b1;
        push_exp(1'b0, 8'hA9, 1'b1);
        step();
        check("first_grant_latency", 32'(sh_load), 32'd1);
        check("load_bit_vld", 32'(bit_vld), 32'd0);
        req0 = 1'b0;
        nb = 0;
        nbusy = 1;
        hold_err = 0;
        for (int i = 0; i < 30 && busy === 1'b1; i++) begin
            step();
            if (bit_vld === 1'b1) begin
                nb++;
                if (sh_ld !== 8'hA9 || sh_dir !== 1'b1 || sh_load !== 1'b0) hold_err++;
            end
            if (busy === 1'b1) nbusy++;
        end
        check("frame_bit_vld_cycles", 32'(nb), 32'd8);
        check("frame_busy_cycles", 32'(nbusy), 32'd11);
        check("frame_shift_hold", 32'(hold_err), 32'd0);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        check("idle_sh_ld_kept", 32'(sh_ld), 32'hA9);

        // Pointer then round-robin arbitration
        for (int i = 0; i < 5; i++) begin
            req0  = tbl[i].r0;
            req1  = tbl[i].r1;
            dir0  = tbl[i].d0;
            dir1  = tbl[i].d1;
            data0 = tbl[i].w0;
            data1 = tbl[i].w1;
            push_exp(tbl[i].own, tbl[i].own ? tbl[i].w1 : tbl[i].w0,
                     tbl[i].own ? tbl[i].d1 : tbl[i].d0);
            g0 = last_grant;
            wait_grant($sformatf("arb%0d_grant", i));
            if (tbl[i].gap != 0) check($sformatf("arb%0d_spacing", i), 32'(last_grant - g0),
                                       32'(tbl[i].gap));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle("arb_idle");
        check("frame_cnt_6", 32'(frame_cnt), 32'd6);

        // Flush in 4th shift cycle with req1 pending
        req0  = 1'b1;
        dir0  = 1'b0;
        data0 = 8'h3C;
        push_exp(1'b0, 8'h3C, 1'b0);
        wait_grant("flush_grant");
        req0  = 1'b0;
        req1  = 1'b1;
        dir1  = 1'b1;
        data1 = 8'h5A;
        repeat (4) step();
        check("flush_pre_bit_vld", 32'(bit_vld), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_bit_vld", 32'(bit_vld), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_frame_cnt", 32'(frame_cnt), 32'd6);
        push_exp(1'b1, 8'h5A, 1'b1);
        step();
        check("flush_next_grant", 32'(sh_load), 32'd1);
        req1 = 1'b0;
        wait_idle("flush_idle");
        check("frame_cnt_7", 32'(frame_cnt), 32'd7);

        // Flush in LOAD, then flush held in IDLE does not block arbitration
        req0  = 1'b1;
        dir0  = 1'b1;
        data0 = 8'hF0;
        push_exp(1'b0, 8'hF0, 1'b1);
        wait_grant("load_flush_grant");
        req0  = 1'b0;
        flush = 1'b1;
        req1  = 1'b1;
        dir1  = 1'b0;
        data1 = 8'h0F;
        step();
        check("load_flush_busy", 32'(busy), 32'd0);
        push_exp(1'b1, 8'h0F, 1'b0);
        step();
        check("idle_flush_grant", 32'(sh_load), 32'd1);
        req1 = 1'b0;
        step();
        flush = 1'b0;
        check("load_flush2_busy", 32'(busy), 32'd0);
        check("load_flush_frame_cnt", 32'(frame_cnt), 32'd7);

        // Flush coinciding with the last shift cycle
        req0  = 1'b1;
        dir0  = 1'b0;
        data0 = 8'h81;
        push_exp(1'b0, 8'h81, 1'b0);
        wait_grant("last_flush_grant");
        req0 = 1'b0;
        repeat (8) step();
        check("last_shift_bit_vld", 32'(bit_vld), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("last_flush_busy", 32'(busy), 32'd0);
        check("last_flush_frame_cnt", 32'(frame_cnt), 32'd7);

        // Asynchronous reset mid-shift
        req0  = 1'b1;
        req1  = 1'b1;
        dir0  = 1'b1;
        data0 = 8'h11;
        dir1  = 1'b1;
        data1 = 8'h22;
        push_exp(1'b1, 8'h22, 1'b1);
        wait_grant("arst_grant");
        repeat (5) step();
        check("arst_pre_bit_vld", 32'(bit_vld), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bit_vld", 32'(bit_vld), 32'd0);
        check("arst_sh_ld", 32'(sh_ld), 32'd0);
        check("arst_sh_dir", 32'(sh_dir), 32'd0);
        check("arst_owner", 32'(owner), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) step();
        rstn = 1'b1;
        push_exp(1'b0, 8'h11, 1'b1);
        step();
        check("arst_post_grant", 32'(sh_load), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle("arst_idle");
        check("arst_frame_cnt_1", 32'(frame_cnt), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
